rep3_serial_tx: RTL

//  Transmit end of the triple-repetition serial link; the receive end majority-votes each group of REP samples.

---
 rtl/rep3_pkg.sv | 22 ++
 rtl/rep_tick_counter.sv | 52 +++++
 rtl/rep3_serial_tx.sv | 137 +++++++++++++
 3 files changed

// File: rtl/rep3_pkg.sv
// Package shared by both ends of the triple-repetition serial link.
// Holds the line FSM state encoding, the line levels for each framing
// symbol, and a helper that gives the length of one frame in clock cycles.
package rep3_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rep3_state_t;

  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  // One START symbol, data_w DATA symbols and one STOP symbol, each held rep cycles.
  function automatic int frame_len(input int data_w, input int rep);
    return (data_w + 2) * rep;
  endfunction

endpackage

// File: rtl/rep_tick_counter.sv
// Repeat counter for one symbol of the repetition link.
// Counts 0..REP-1 while enabled, wrapping back to 0, and flags the final
// repeat of the current symbol. Also used by the receiver to group samples.
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   synchronous active-low reset
//   en_i        in   advance the count this cycle
//   clr_i       in   force the count to 0 this cycle (wins over en_i)
//   cnt_o       out  current repeat index
//   last_tick_o out  high while the count sits at REP-1
module rep_tick_counter #(
  parameter int REP = 3,
  localparam int CW = (REP > 1) ? $clog2(REP) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o,
  output logic          last_tick_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: clear has priority, otherwise wrap at the last repeat.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      if (cnt_q == CW'(REP - 1)) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o       = cnt_q;
  assign last_tick_o = (cnt_q == CW'(REP - 1));

endmodule

// File: rtl/rep3_serial_tx.sv
// Transmit end of the triple-repetition serial link.
// Takes parallel words on a valid/ready handshake and sends each as a frame:
// one START symbol, DATA_W data symbols LSB first, one STOP symbol. Every
// symbol is held for REP cycles so the receiver can majority-vote it.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   in_data    in   word to send, captured only on acceptance
//   in_valid   in   source has a word
//   in_ready   out  a word can be accepted this cycle
//   tx_out     out  serial line, idles high (registered)
//   tx_busy    out  frame in progress (registered)
//   frame_done out  one-cycle pulse on the last STOP cycle (registered)
module rep3_serial_tx
  import rep3_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int REP    = 3,
  localparam int RCW   = $clog2(REP),
  localparam int BCW   = (DATA_W > 1) ? $clog2(DATA_W + 1) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              tx_out,
  output logic              tx_busy,
  output logic              frame_done
);

  // Reject parameter values the voting receiver cannot work with.
  if (REP < 3 || (REP % 2) == 0) begin : g_bad_rep
    $error("rep3_serial_tx: REP must be odd and >= 3");
  end
  if (DATA_W < 1 || DATA_W > 32) begin : g_bad_width
    $error("rep3_serial_tx: DATA_W must be in 1..32");
  end

  rep3_state_t       state_q;
  logic [DATA_W-1:0] shreg_q;
  logic [DATA_W-1:0] shreg_shift;
  logic [BCW-1:0]    bit_cnt_q;
  logic              tx_out_q;
  logic              tx_busy_q;
  logic              frame_done_q;
  logic [RCW-1:0]    rep_cnt;
  logic              last_tick;
  logic              accept;

  // Ready depends on registers only, so a source may wait for ready before raising valid.
  assign in_ready    = (state_q == IDLE) || ((state_q == STOP) && last_tick);
  assign accept      = in_valid && in_ready;
  assign shreg_shift = shreg_q >> 1;

  // The repeat counter runs for every symbol of a frame; acceptance restarts it
  // so a new frame always begins on repeat 0.
  rep_tick_counter #(
    .REP (REP)
  ) u_rep_cnt (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (state_q != IDLE),
    .clr_i       (accept),
    .cnt_o       (rep_cnt),
    .last_tick_o (last_tick)
  );

  // Frame FSM. Outputs are registered, so each transition loads the line level
  // of the symbol that starts on the following cycle. frame_done is raised one
  // edge early so it lines up with the final STOP repeat.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      tx_out_q     <= IDLE_LVL;
      tx_busy_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            state_q   <= START;
            shreg_q   <= in_data;
            tx_out_q  <= START_LVL;
            tx_busy_q <= 1'b1;
          end
        end
        START: begin
          if (last_tick) begin
            state_q   <= DATA;
            bit_cnt_q <= '0;
            tx_out_q  <= shreg_q[0];
          end
        end
        DATA: begin
          if (last_tick) begin
            shreg_q <= shreg_shift;
            if (bit_cnt_q == BCW'(DATA_W - 1)) begin
              state_q  <= STOP;
              tx_out_q <= STOP_LVL;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
              tx_out_q  <= shreg_shift[0];
            end
          end
        end
        STOP: begin
          if (rep_cnt == RCW'(REP - 2)) begin
            frame_done_q <= 1'b1;
          end
          if (last_tick) begin
            if (accept) begin
              state_q  <= START;
              shreg_q  <= in_data;
              tx_out_q <= START_LVL;
            end else begin
              state_q   <= IDLE;
              tx_out_q  <= IDLE_LVL;
              tx_busy_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign tx_out     = tx_out_q;
  assign tx_busy    = tx_busy_q;
  assign frame_done = frame_done_q;

endmodule
